// File: rtl/spi_frame_ctrl.sv
// Serial frame controller: fetches NWORDS frame-buffer words and shifts each one
// out MSB-first as a chip-select-framed transfer. Optional macro SPI_FRAME_AUTOREFRESH_EN.
module spi_frame_ctrl #(
  parameter int DIV    = 2,
  parameter int WORD_W = 16,
  parameter int NWORDS = 8,
  localparam int ADDR_W = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] word_addr,
  input  logic [WORD_W-1:0] word_data,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WORD_W) + 1;
  localparam int GAP_W = $clog2(2 * DIV);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t            state_reg;
  logic [WORD_W-1:0] shift_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;

  logic tick;
  logic last_bit;
  logic last_word;
  logic gap_end;
  logic go;

  assign tick      = (div_cnt_reg == DIV_W'(DIV - 1));
  assign last_bit  = (bit_cnt_reg == BIT_W'(WORD_W - 1));
  assign last_word = (word_addr == ADDR_W'(NWORDS - 1));
  assign gap_end   = (gap_cnt_reg == GAP_W'(2 * DIV - 1));

`ifdef SPI_FRAME_AUTOREFRESH_EN
  // Once armed by the first accepted start, every return to IDLE re-launches a frame.
  logic armed_reg;
  assign go = start | armed_reg;
`else
  assign go = start;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      word_addr   <= '0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      cs_n        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SPI_FRAME_AUTOREFRESH_EN
      armed_reg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (go) begin
            state_reg <= LOAD;
            busy      <= 1'b1;
            word_addr <= '0;
`ifdef SPI_FRAME_AUTOREFRESH_EN
            armed_reg <= 1'b1;
`endif
          end
        end

        LOAD: begin
          shift_reg   <= word_data;
          mosi        <= word_data[WORD_W-1];
          cs_n        <= 1'b0;
          div_cnt_reg <= '0;
          bit_cnt_reg <= '0;
          state_reg   <= SHIFT;
        end

        SHIFT: begin
          if (tick) begin
            div_cnt_reg <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // Falling edge: advance to the next bit, or close the word on the last one.
              sclk        <= 1'b0;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (last_bit) begin
                state_reg   <= GAP;
                cs_n        <= 1'b1;
                mosi        <= 1'b0;
                gap_cnt_reg <= '0;
              end else begin
                shift_reg <= shift_reg << 1;
                mosi      <= shift_reg[WORD_W-2];
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end

        GAP: begin
          if (gap_end) begin
            if (last_word) begin
              state_reg <= IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              word_addr <= '0;
            end else begin
              state_reg <= LOAD;
              word_addr <= word_addr + 1'b1;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: a DIV=2 instance on a frame buffer and a DIV=1
// instance on a fixed word, each watched by a small SPI slave model.
module tb_spi_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic [2:0]  word_addr, word_addr1;
  logic [15:0] word_data;
  logic [15:0] word_data1 = 16'hA5C3;
  logic        sclk, mosi, cs_n, busy, done;
  logic        sclk1, mosi1, cs_n1, busy1, done1;

  logic [15:0] fb [8];
  initial for (int i = 0; i < 8; i++) fb[i] = {8'(i + 1), 8'(i)};
  assign word_data = fb[word_addr];

  spi_frame_ctrl #(.DIV(2), .WORD_W(16), .NWORDS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .word_addr(word_addr), .word_data(word_data),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done)
  );

  spi_frame_ctrl #(.DIV(1), .WORD_W(16), .NWORDS(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .word_addr(word_addr1), .word_data(word_data1),
    .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1), .done(done1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model for the DIV=2 instance
  logic [15:0] wq[$];
  int          bq[$];
  int          lq[$];
  logic [15:0] sh = '0;
  int          nbits = 0, cs_len = 0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;

  always @(negedge clk) begin
    if (!cs_n && prev_cs) begin sh = '0; nbits = 0; cs_len = 0; end
    if (!cs_n) begin
      cs_len++;
      if (sclk && !prev_sclk) begin sh = {sh[14:0], mosi}; nbits++; end
    end
    if (cs_n && !prev_cs) begin
      wq.push_back(sh); bq.push_back(nbits); lq.push_back(cs_len);
      $display("xfer div2: word=%h bits=%0d cs_low=%0d at cycle %0d", sh, nbits, cs_len, cyc);
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  // Slave model for the DIV=1 instance, also counting cycles where sclk failed to toggle
  logic [15:0] wq1[$];
  int          bq1[$];
  logic [15:0] sh1 = '0;
  int          nbits1 = 0, stuck1 = 0;
  logic        prev_sclk1 = 1'b0, prev_cs1 = 1'b1;

  always @(negedge clk) begin
    if (!cs_n1 && prev_cs1) begin sh1 = '0; nbits1 = 0; end
    if (!cs_n1) begin
      if (sclk1 && !prev_sclk1) begin sh1 = {sh1[14:0], mosi1}; nbits1++; end
      if (!prev_cs1 && (sclk1 == prev_sclk1)) stuck1++;
    end
    if (cs_n1 && !prev_cs1) begin
      wq1.push_back(sh1); bq1.push_back(nbits1);
      $display("xfer div1: word=%b bits=%0d at cycle %0d", sh1, nbits1, cyc);
    end
    prev_sclk1 = sclk1;
    prev_cs1   = cs_n1;
  end

  task automatic wait_done(input bit which, input int limit, output int at);
    int k = 0;
    while (!(which ? done1 : done) && k < limit) begin
      @(negedge clk);
      k++;
    end
    at = cyc;
    check(which ? "done1_seen" : "done_seen", 32'(which ? done1 : done), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wq.delete(); bq.delete(); lq.delete(); wq1.delete(); bq1.delete();
  endtask

  int t, acc, bad, nd, lowc;
  int dt [3];

  initial begin
    // Reset values and quiet idle
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(word_addr), 32'd0);
    check("rst1_cs_n", 32'(cs_n1), 32'd1);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sclk || !cs_n || mosi || busy || done) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Full frame at DIV=2
    wq.delete(); bq.delete(); lq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    check("load_busy", 32'(busy), 32'd1);
    check("load_cs_n", 32'(cs_n), 32'd1);
    @(negedge clk);
    check("first_cs_n", 32'(cs_n), 32'd0);
    check("first_mosi", 32'(mosi), 32'(fb[0][15]));
    wait_done(1'b0, 1000, t);
    check("frame_cycles", 32'(t - acc), 32'd552);
    check("done_busy", 32'(busy), 32'd0);
    check("done_addr", 32'(word_addr), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("word_count", 32'(wq.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("word%0d", i), 32'((i < wq.size()) ? wq[i] : 16'hxxxx), 32'(fb[i]));
      check($sformatf("bits%0d", i), 32'((i < bq.size()) ? bq[i] : -1), 32'd16);
      check($sformatf("cs_low%0d", i), 32'((i < lq.size()) ? lq[i] : -1), 32'd64);
    end

`ifndef SPI_FRAME_AUTOREFRESH_EN
    // start held high for a whole frame gives exactly one frame
    do_reset();
    start = 1'b1;
    wait_done(1'b0, 1000, t);
    start = 1'b0;
    check("held_words", 32'(wq.size()), 32'd8);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy) bad++;
    end
    check("held_no_refire", 32'(bad), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    wait_done(1'b0, 1000, t);
`endif

    // Reset in the middle of a word
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (190) @(negedge clk);
    check("pre_rst_cs_n", 32'(cs_n), 32'd0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_n", 32'(cs_n), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(word_addr), 32'd0);
    reset = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("rst_no_done", 32'(nd), 32'd0);
    wq.delete(); bq.delete(); lq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 1000, t);
    check("rst_words", 32'(wq.size()), 32'd8);
    check("rst_first", 32'((wq.size() > 0) ? wq[0] : 16'hxxxx), 32'(fb[0]));
    check("rst_last", 32'((wq.size() > 7) ? wq[7] : 16'hxxxx), 32'(fb[7]));

    // DIV=1 instance, fixed word 0xA5C3
    do_reset();
    stuck1 = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    acc = cyc;
    wait_done(1'b1, 1000, t);
    check("div1_frame_cycles", 32'(t - acc), 32'd280);
    check("div1_words", 32'(wq1.size()), 32'd8);
    check("div1_word", 32'((wq1.size() > 0) ? wq1[0] : 16'hxxxx), 32'h0000A5C3);
    check("div1_bits", 32'((bq1.size() > 0) ? bq1[0] : -1), 32'd16);
    check("div1_toggle", 32'(stuck1), 32'd0);

`ifdef SPI_FRAME_AUTOREFRESH_EN
    // One start, three back-to-back frames
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    nd = 0;
    lowc = 0;
    for (int k = 0; k < 3000 && nd < 3; k++) begin
      @(negedge clk);
      if (done) begin dt[nd] = cyc; nd++; end
      if (!busy) lowc++;
    end
    check("ar_frames", 32'(nd), 32'd3);
    check("ar_first", 32'(dt[0] - acc), 32'd552);
    check("ar_gap1", 32'(dt[1] - dt[0]), 32'd553);
    check("ar_gap2", 32'(dt[2] - dt[1]), 32'd553);
    check("ar_busy_low", 32'(lowc), 32'd3);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
